hazard_sequencer: RTL

Pipeline hazard and stall sequencer for the Osiris I five-stage RV32I core. It decides, every cycle, which stage registers hold, which get a bubble, and which operand-forwarding path the EX stage uses. It drives the IF/ID, ID/EX, EX/MEM and MEM/WB register enables and clears. It also keeps ID-stage decode, including the immediate extension, consistent across load-use stalls, taken branches and multi-cycle data-memory accesses. It also tracks memory-wait timeouts and keeps saturating stall and flush counters for debug.

---
 rtl/hazard_sequencer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/hazard_sequencer.sv
// Hazard and stall sequencer for the Osiris I five-stage RV32I core.
// Drives stage holds/bubbles, EX forwarding selects and memory-timeout state.
module hazard_sequencer #(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       i_rs1_ID,
   input  logic [4:0]       i_rs2_ID,
   input  logic [4:0]       i_rs1_EX,
   input  logic [4:0]       i_rs2_EX,
   input  logic [4:0]       i_rd_EX,
   input  logic             i_mem_read_EX,
   input  logic             i_pc_src_EX,
   input  logic [4:0]       i_rd_MEM,
   input  logic             i_reg_write_MEM,
   input  logic [4:0]       i_rd_WB,
   input  logic             i_reg_write_WB,
   input  logic             i_dmem_req_MEM,
   input  logic             i_dmem_ack_MEM,
   output logic             o_stall_IF,
   output logic             o_stall_ID,
   output logic             o_stall_EX,
   output logic             o_stall_MEM,
   output logic             o_flush_ID,
   output logic             o_flush_EX,
   output logic             o_flush_WB,
   output logic [1:0]       o_forward_a_EX,
   output logic [1:0]       o_forward_b_EX,
   output logic             o_mem_err,
   output logic [CNT_W-1:0] o_stall_cnt,
   output logic [CNT_W-1:0] o_flush_cnt
);

   typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

   localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

   state_t     state;
   logic [7:0] wait_cnt;
   logic       mem_wait;
   logic       load_use;
   logic       hold;
   logic       branch;
   logic       bubble;

   assign mem_wait = i_dmem_req_MEM & ~i_dmem_ack_MEM;
   assign load_use = i_mem_read_EX & (i_rd_EX != 5'd0) &
                     ((i_rd_EX == i_rs1_ID) | (i_rd_EX == i_rs2_ID));

   // A frozen pipeline masks branch and load-use; they re-evaluate on release.
   assign hold   = (state == ERR) | mem_wait;
   assign branch = ~hold & i_pc_src_EX;
   assign bubble = ~hold & ~i_pc_src_EX & load_use;

   always_comb begin
      o_stall_IF  = hold | bubble;
      o_stall_ID  = hold | bubble;
      o_stall_EX  = hold;
      o_stall_MEM = hold;
      o_flush_ID  = branch;
      o_flush_EX  = branch | bubble;
      o_flush_WB  = hold;
   end

   function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
      if (i_reg_write_MEM && (i_rd_MEM != 5'd0) && (i_rd_MEM == rs))
         return 2'b10;
      else if (i_reg_write_WB && (i_rd_WB != 5'd0) && (i_rd_WB == rs))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   assign o_forward_a_EX = fwd_sel(i_rs1_EX);
   assign o_forward_b_EX = fwd_sel(i_rs2_EX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         wait_cnt  <= 8'd0;
         o_mem_err <= 1'b0;
      end else begin
         unique case (state)
            RUN: begin
               if (mem_wait) begin
                  state    <= MEM_WAIT;
                  wait_cnt <= 8'd1;
               end else begin
                  wait_cnt <= 8'd0;
               end
            end
            MEM_WAIT: begin
               if (!mem_wait) begin
                  state    <= RUN;
                  wait_cnt <= 8'd0;
               end else if (wait_cnt == TMO) begin
                  state     <= ERR;
                  o_mem_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            ERR: begin
               state     <= ERR;
               o_mem_err <= 1'b1;
            end
            default: begin
               state    <= RUN;
               wait_cnt <= 8'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_stall_cnt <= '0;
         o_flush_cnt <= '0;
      end else begin
         if (o_stall_IF && (o_stall_cnt != '1))
            o_stall_cnt <= o_stall_cnt + CNT_W'(1);
         if (branch && (o_flush_cnt != '1))
            o_flush_cnt <= o_flush_cnt + CNT_W'(1);
      end
   end

endmodule
